// File: rtl/xor_share_ctrl.sv
// Purpose: round-robin controller sharing one N-bit XOR datapath (y = a ^ b) between two requesters.
// Latency: handshake at edge T -> res_valid high after edge T+1; accepts at least 3 cycles apart.
// Backpressure: result held in HOLD until res_ready; both requester readies stay low while busy.
//
// Ports:
//   clk, rst                     clock (rising edge), asynchronous active-high reset
//   req0_valid/_a/_b, req0_ready requester 0 operand pair, valid/ready handshake
//   req1_valid/_a/_b, req1_ready requester 1 operand pair, valid/ready handshake
//   res_valid, res_data, res_id  registered result and the id of the requester that produced it
//   res_ready                    consumer accepts the result
//   busy                         high while an operation is in EXEC or HOLD
//   res_parity                   reduction XOR of res_data, present only with XOR_PARITY_EN defined
//
// Optional feature macro: XOR_PARITY_EN (adds the res_parity output).
module xor_share_ctrl #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req0_valid,
    input  logic [N-1:0] req0_a,
    input  logic [N-1:0] req0_b,
    output logic         req0_ready,
    input  logic         req1_valid,
    input  logic [N-1:0] req1_a,
    input  logic [N-1:0] req1_b,
    output logic         req1_ready,
    output logic         res_valid,
    output logic [N-1:0] res_data,
    output logic         res_id,
    input  logic         res_ready,
`ifdef XOR_PARITY_EN
    output logic         res_parity,
`endif
    output logic         busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t       state;
    state_t       state_nxt;
    logic         rr_ptr;      // requester preferred when both are valid
    logic         grant_id;    // requester whose operands sit in op_a/op_b
    logic [N-1:0] op_a;
    logic [N-1:0] op_b;

    // Selection and next state. A ready is only ever raised alongside its
    // valid, so a high ready is itself the handshake.
    always_comb begin
        state_nxt  = state;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        case (state)
            IDLE: begin
                if (req0_valid && (!req1_valid || !rr_ptr)) begin
                    req0_ready = 1'b1;
                    state_nxt  = EXEC;
                end else if (req1_valid) begin
                    req1_ready = 1'b1;
                    state_nxt  = EXEC;
                end
            end
            EXEC: state_nxt = HOLD;
            HOLD: begin
                if (res_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            rr_ptr     <= 1'b0;
            grant_id   <= 1'b0;
            op_a       <= '0;
            op_b       <= '0;
            res_data   <= '0;
            res_id     <= 1'b0;
            res_valid  <= 1'b0;
`ifdef XOR_PARITY_EN
            res_parity <= 1'b0;
`endif
        end else begin
            state <= state_nxt;

            // Latch the winner's operands so later input changes cannot leak in.
            if (req0_ready || req1_ready) begin
                op_a     <= req1_ready ? req1_a : req0_a;
                op_b     <= req1_ready ? req1_b : req0_b;
                grant_id <= req1_ready;
                rr_ptr   <= ~req1_ready;   // the loser gets priority next time
            end

            if (state == EXEC) begin
                res_data   <= op_a ^ op_b;
                res_id     <= grant_id;
                res_valid  <= 1'b1;
`ifdef XOR_PARITY_EN
                res_parity <= ^(op_a ^ op_b);
`endif
            end

            if (state == HOLD && res_ready) begin
                res_valid <= 1'b0;
            end
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_xor_share_ctrl.sv
module tb_xor_share_ctrl;

    localparam int N = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         req0_valid;
    logic [N-1:0] req0_a;
    logic [N-1:0] req0_b;
    logic         req0_ready;
    logic         req1_valid;
    logic [N-1:0] req1_a;
    logic [N-1:0] req1_b;
    logic         req1_ready;
    logic         res_valid;
    logic [N-1:0] res_data;
    logic         res_id;
    logic         res_ready;
    logic         busy;
`ifdef XOR_PARITY_EN
    logic         res_parity;
`endif

    typedef struct packed {
        logic [N-1:0] data;
        logic         id;
        logic         parity;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    xor_share_ctrl #(.N(N)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_ready (req1_ready),
        .res_valid  (res_valid),
        .res_data   (res_data),
        .res_id     (res_id),
        .res_ready  (res_ready),
`ifdef XOR_PARITY_EN
        .res_parity (res_parity),
`endif
        .busy       (busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic exp_t mk_exp(input logic [N-1:0] a, input logic [N-1:0] b, input logic id);
        exp_t e;
        e.data   = a ^ b;
        e.id     = id;
        e.parity = ^(a ^ b);
        return e;
    endfunction

    // Scoreboard: every result the consumer accepts must be the next one queued.
    always @(negedge clk) begin
        if (!rst) begin
            check("ready_exclusive", {31'd0, req0_ready & req1_ready}, 32'd0);
            if (res_valid && res_ready) begin
                check("sb_nonempty", {31'd0, sb.size() != 0}, 32'd1);
                if (sb.size() != 0) begin
                    exp_t e;
                    e = sb.pop_front();
                    check("sb_data", {24'd0, res_data}, {24'd0, e.data});
                    check("sb_id", {31'd0, res_id}, {31'd0, e.id});
`ifdef XOR_PARITY_EN
                    check("sb_parity", {31'd0, res_parity}, {31'd0, e.parity});
`endif
                end
            end
        end
    end

    // One transaction from requester sel; result held for hold_cycles before acceptance.
    // With bp set, requester 1 waves random operands at the busy controller meanwhile.
    task automatic run_op(input logic sel, input logic [N-1:0] a, input logic [N-1:0] b,
                          input int hold_cycles, input logic bp);
        logic [N-1:0] y;
        y = a ^ b;
        @(posedge clk); #1;
        if (sel) begin
            req1_valid = 1'b1; req1_a = a; req1_b = b;
        end else begin
            req0_valid = 1'b1; req0_a = a; req0_b = b;
        end
        sb.push_back(mk_exp(a, b, sel));
        #1;
        check("grant_ready0", {31'd0, req0_ready}, {31'd0, ~sel});
        check("grant_ready1", {31'd0, req1_ready}, {31'd0, sel});
        @(posedge clk); #1;               // handshake edge passed, now EXEC
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        #1;
        check("exec_busy", {31'd0, busy}, 32'd1);
        check("exec_no_result", {31'd0, res_valid}, 32'd0);
        @(posedge clk); #1;               // EXEC edge passed, now HOLD
        for (int i = 0; i < hold_cycles; i++) begin
            if (bp) begin
                req1_valid = 1'b1;
                req1_a     = N'($urandom);
                req1_b     = N'($urandom);
            end
            #1;
            check("hold_valid", {31'd0, res_valid}, 32'd1);
            check("hold_data", {24'd0, res_data}, {24'd0, y});
            check("hold_id", {31'd0, res_id}, {31'd0, sel});
            check("hold_ready0", {31'd0, req0_ready}, 32'd0);
            check("hold_ready1", {31'd0, req1_ready}, 32'd0);
            @(posedge clk); #1;
        end
        req1_valid = 1'b0;
        res_ready  = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
        #1;
        check("after_accept_valid", {31'd0, res_valid}, 32'd0);
        check("after_accept_busy", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        rst        = 1'b1;
        req0_valid = 1'b0; req0_a = '0; req0_b = '0;
        req1_valid = 1'b0; req1_a = '0; req1_b = '0;
        res_ready  = 1'b0;
        #2;
        check("rst_valid", {31'd0, res_valid}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_data", {24'd0, res_data}, 32'd0);
        check("rst_id", {31'd0, res_id}, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Single requester, result held across a short stall.
        run_op(1'b0, 8'hAA, 8'h55, 2, 1'b0);
        // Backpressure: 5-cycle stall with requester 1 changing operands.
        run_op(1'b0, 8'h0F, 8'h3C, 5, 1'b1);
        // Edge values and parity cases, both requesters.
        run_op(1'b0, 8'hFF, 8'hFF, 1, 1'b0);
        run_op(1'b1, 8'h00, 8'hFF, 1, 1'b0);
        run_op(1'b1, 8'b0101_1010, 8'b0011_1100, 1, 1'b0);
        run_op(1'b0, 8'h01, 8'h00, 1, 1'b0);
        check("sb_drain_single", sb.size(), 32'd0);

        // Reset while a 0xFF result is pending in HOLD: discarded, nothing emitted.
        @(posedge clk); #1;
        req0_valid = 1'b1; req0_a = 8'hF0; req0_b = 8'h0F;
        @(posedge clk); #1;
        req0_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("pre_rst_hold_data", {24'd0, res_data}, 32'h0000_00FF);
        rst = 1'b1;
        #1;
        check("mid_rst_valid", {31'd0, res_valid}, 32'd0);
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        check("mid_rst_data", {24'd0, res_data}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Contention: both valid continuously, consumer always ready.
        @(posedge clk); #1;
        req0_valid = 1'b1; req0_a = 8'h0F; req0_b = 8'hF0;
        req1_valid = 1'b1; req1_a = 8'h5A; req1_b = 8'h3C;
        res_ready  = 1'b1;
        for (int k = 0; k < 6; k++) begin
            if (k % 2 == 0) sb.push_back(mk_exp(8'h0F, 8'hF0, 1'b0));
            else            sb.push_back(mk_exp(8'h5A, 8'h3C, 1'b1));
        end
        #1;
        check("post_rst_first_grant0", {31'd0, req0_ready}, 32'd1);
        check("post_rst_first_grant1", {31'd0, req1_ready}, 32'd0);
        repeat (16) @(posedge clk);       // six grants at 3-cycle spacing
        #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        res_ready = 1'b0;
        check("sb_drain_contention", sb.size(), 32'd0);
        check("end_busy", {31'd0, busy}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/xor_share_ctrl.md
Name: xor_share_ctrl

Overview:
- Round-robin controller sharing one N-bit XOR datapath (y = a ^ b) between two requesters.
- Each requester offers an operand pair over a valid/ready handshake.
- Controller latches the winner's operands, computes the XOR in the shared datapath and holds a registered result, tagged with the requester id, until the consumer accepts it.
- Sits between lab stimulus sources (switch banks or a test driver) and the result display/consumer.

Parameters:
- N, 8, operand and result width in bits (N >= 1).

Ports:
- clk  input  1  system clock; rising edge.
- rst  input  1  asynchronous, active-high reset.
- req0_valid  input  1  requester 0 has an operand pair.
- req0_a  input  N  requester 0 operand a.
- req0_b  input  N  requester 0 operand b.
- req0_ready  output  1  requester 0 handshake accepted this cycle.
- req1_valid  input  1  requester 1 has an operand pair.
- req1_a  input  N  requester 1 operand a.
- req1_b  input  N  requester 1 operand b.
- req1_ready  output  1  requester 1 handshake accepted this cycle.
- res_valid  output  1  result register holds a valid result.
- res_data  output  N  registered XOR result.
- res_id  output  1  requester that produced res_data (0 or 1).
- res_ready  input  1  consumer accepts the result.
- busy  output  1  high in EXEC or HOLD.

Behaviour:
- Reset: asynchronous; takes effect immediately. State=IDLE, rr_ptr=0 (requester 0 preferred), op_a=op_b=0, res_data=0, res_id=0, res_valid=0, busy=0.
- Any operation in progress at reset is discarded; no result is emitted.
- FSM states: IDLE, EXEC, HOLD.
- IDLE, requester selection:
  - Only one valid high: that requester wins, regardless of rr_ptr.
  - Both valid high: requester rr_ptr wins.
  - Winner's reqX_ready is driven combinationally high in the same cycle. Loser's ready stays 0.
  - Handshake = valid & ready. On it: latch reqX_a/reqX_b into op_a/op_b, store grant id, set rr_ptr = ~winner, go to EXEC.
  - No valid high: stay in IDLE; both readies are 0.
- EXEC (1 cycle): res_data <= op_a ^ op_b, res_id <= grant id, res_valid <= 1; go to HOLD.
- HOLD: res_valid, res_data and res_id held stable. On res_ready=1, clear res_valid at that edge and go to IDLE.
- Latency: handshake at edge T gives res_valid=1 after edge T+1. Minimum spacing between accepts is 3 cycles.
- reqX_ready is 0 in EXEC and HOLD. Operand changes there are ignored because operands are latched.
- A requester dropping valid before ready has no effect and no penalty.
- res_ready high while res_valid=0 is ignored.
- A requester that keeps valid asserted cannot starve the other: strict alternation applies when both stay valid.
- Width rule: bitwise XOR, N bits in and N bits out, no carries and no truncation.

Optional Feature:
- Macro: XOR_PARITY_EN.
- Defined: adds output res_parity (1 bit) = reduction XOR of res_data, registered alongside res_data in EXEC. Reset value 0; held through HOLD.
- Undefined: port and logic absent. All other behaviour is identical.

Test Plan (N=8):
- Reset: assert rst mid-HOLD (result 0xFF pending) -> res_valid=0, busy=0, res_data=0x00 immediately. After release, the first simultaneous request grants requester 0.
- Single requester: req0 a=0xAA b=0x55 -> req0_ready=1 in the same cycle. Two cycles later res_valid=1, res_data=0xFF, res_id=0. Held until res_ready pulse, then IDLE.
- Contention: both valid continuously. req0 a=0x0F b=0xF0, req1 a=0x5A b=0x3C, res_ready tied 1 -> results alternate: 0xFF id0, 0x66 id1, 0xFF id0, ... Never two consecutive grants to the same id.
- Backpressure: res_ready=0 for 5 cycles after res_valid -> res_data and res_id stable. Both readies stay 0. Operand changes on req1 do not alter the result.
- Edge values: a=b=0xFF gives 0x00. a=0x00 b=0xFF gives 0xFF. a=0b01011010 b=0b00111100 gives 0b01100110.
- XOR_PARITY_EN: the 0x66 case gives res_parity=0; a=0x01 b=0x00 gives res_data=0x01, res_parity=1.
